// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the program counter control, issues single-outstanding
// instruction memory requests and buffers {pc, instruction} pairs for decode.
module fetch_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 16,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  output logic          pc_ctrl,
  output logic [AW-1:0] pc_next,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic          instr_valid,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     req_pc_q, req_pc_d;
  logic [AW+IW-1:0]  mem_q [DEPTH];
  logic [AW+IW-1:0]  head;
  logic [CW:0]       occupancy;
  logic              space;
  logic              issue;
  logic              push;
  logic              pop;

  // An outstanding request reserves a buffer slot so its response can never overflow.
  assign occupancy = {1'b0, count_q} + (CW+1)'(state_q == S_WAIT);
  assign space     = occupancy < (CW+1)'(DEPTH);

  assign issue       = !redirect_valid && (state_q == S_REQ) && imem_gnt && space;
  assign push        = !redirect_valid && (state_q == S_WAIT) && imem_rvalid;
  assign instr_valid = (count_q != '0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;

  assign head     = mem_q[rd_ptr_q];
  assign instr_pc = head[AW+IW-1:IW];
  assign instr    = head[IW-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      state_d = S_REQ;
    end else if (redirect_valid) begin
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) state_d = S_DROP;
      else                                                          state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ:   if (imem_gnt && space) state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid)       state_d = S_REQ;
        S_DROP:  if (imem_rvalid)       state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    pc_ctrl   = 1'b1;
    pc_next   = pc;
    imem_req  = 1'b0;
    imem_addr = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (state_q == S_REQ) begin
      imem_req = space;
      if (imem_gnt && space) pc_ctrl = 1'b0;
    end
  end

  // Buffer bookkeeping; a redirect flushes everything, including a same-cycle response.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    req_pc_d = issue ? pc : req_pc_q;
    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              mem_q[gi] <= '0;
        else if (push && wr_ptr_q == PW'(gi))    mem_q[gi] <= {req_pc_q, imem_rdata};
      end
    end
  endgenerate

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table with a program counter model,
// followed by a hand-written asynchronous-reset sequence.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic        pc_ctrl;
  logic [15:0] pc_next;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.DEPTH(2), .AW(16), .IW(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_ctrl        (pc_ctrl),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: load pc_next when ctrl=1, otherwise advance by 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= 16'h0000;
    else if (pc_ctrl) pc <= pc_next;
    else              pc <= pc + 16'd4;
  end

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [15:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_ctrl;
    logic [15:0] e_next;
    logic        e_iv;
    logic [15:0] e_ipc;
    logic [31:0] e_instr;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vec [64];
  int   nv = 0;

  function automatic int unsigned d(input int unsigned k);
    return 32'hC0DE_0000 + k;
  endfunction

  task automatic add(input int unsigned r, rv, rpc, g, vl, rd, rdy,
                     input int unsigned ereq, eaddr, ectl, enext, eiv, eipc, einstr, epc);
    vec[nv].rst_n   = r[0];
    vec[nv].rv      = rv[0];
    vec[nv].rpc     = 16'(rpc);
    vec[nv].gnt     = g[0];
    vec[nv].rvalid  = vl[0];
    vec[nv].rdata   = rd;
    vec[nv].rdy     = rdy[0];
    vec[nv].e_req   = ereq[0];
    vec[nv].e_addr  = 16'(eaddr);
    vec[nv].e_ctrl  = ectl[0];
    vec[nv].e_next  = 16'(enext);
    vec[nv].e_iv    = eiv[0];
    vec[nv].e_ipc   = 16'(eipc);
    vec[nv].e_instr = einstr;
    vec[nv].e_pc    = 16'(epc);
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

    //   rst rv rpc    gnt rvl rdata        rdy | req addr    ctl next    iv ipc    instr        pc
    // Streaming fetch with immediate grant and 1-cycle response
    add(0, 0, 0,      0,  0,  0,           1,   0,  0,      1,  0,      0, 0,      0,           0);
    add(1, 0, 0,      1,  0,  0,           1,   0,  0,      1,  0,      0, 0,      0,           0);
    add(1, 0, 0,      1,  0,  0,           1,   1,  0,      0,  0,      0, 0,      0,           0);
    add(1, 0, 0,      0,  1,  d(0),        1,   0,  0,      1,  4,      0, 0,      0,           4);
    add(1, 0, 0,      1,  0,  0,           1,   1,  4,      0,  0,      1, 0,      d(0),        4);
    add(1, 0, 0,      0,  1,  d(1),        1,   0,  0,      1,  8,      0, 0,      0,           8);
    add(1, 0, 0,      1,  0,  0,           1,   1,  8,      0,  0,      1, 4,      d(1),        8);
    add(1, 0, 0,      0,  1,  d(2),        1,   0,  0,      1,  'hc,    0, 0,      0,           'hc);
    add(1, 0, 0,      0,  0,  0,           1,   1,  'hc,    1,  'hc,    1, 8,      d(2),        'hc);
    // Decode stalled: buffer fills, fetch stops, then drains in order and resumes
    add(0, 0, 0,      0,  0,  0,           0,   0,  0,      1,  0,      0, 0,      0,           0);
    add(1, 0, 0,      0,  0,  0,           0,   0,  0,      1,  0,      0, 0,      0,           0);
    add(1, 0, 0,      1,  0,  0,           0,   1,  0,      0,  0,      0, 0,      0,           0);
    add(1, 0, 0,      0,  1,  d(3),        0,   0,  0,      1,  4,      0, 0,      0,           4);
    add(1, 0, 0,      1,  0,  0,           0,   1,  4,      0,  0,      1, 0,      d(3),        4);
    add(1, 0, 0,      0,  1,  d(4),        0,   0,  0,      1,  8,      1, 0,      d(3),        8);
    add(1, 0, 0,      1,  0,  0,           0,   0,  0,      1,  8,      1, 0,      d(3),        8);
    add(1, 0, 0,      0,  0,  0,           0,   0,  0,      1,  8,      1, 0,      d(3),        8);
    add(1, 0, 0,      0,  0,  0,           1,   0,  0,      1,  8,      1, 0,      d(3),        8);
    add(1, 0, 0,      0,  0,  0,           1,   1,  8,      1,  8,      1, 4,      d(4),        8);
    add(1, 0, 0,      1,  0,  0,           1,   1,  8,      0,  0,      0, 0,      0,           8);
    add(1, 0, 0,      0,  1,  d(5),        1,   0,  0,      1,  'hc,    0, 0,      0,           'hc);
    add(1, 0, 0,      0,  0,  0,           1,   1,  'hc,    1,  'hc,    1, 8,      d(5),        'hc);
    // Redirect while waiting on 0x0004: late response dropped, refetch from 0x0100
    add(0, 0, 0,      0,  0,  0,           1,   0,  0,      1,  0,      0, 0,      0,           0);
    add(1, 0, 0,      0,  0,  0,           1,   0,  0,      1,  0,      0, 0,      0,           0);
    add(1, 0, 0,      1,  0,  0,           1,   1,  0,      0,  0,      0, 0,      0,           0);
    add(1, 0, 0,      0,  1,  d(6),        1,   0,  0,      1,  4,      0, 0,      0,           4);
    add(1, 0, 0,      1,  0,  0,           1,   1,  4,      0,  0,      1, 0,      d(6),        4);
    add(1, 1, 'h100,  0,  0,  0,           1,   0,  0,      1,  'h100,  0, 0,      0,           8);
    add(1, 0, 0,      1,  0,  0,           1,   0,  0,      1,  'h100,  0, 0,      0,           'h100);
    add(1, 0, 0,      0,  1,  'hBAD0BAD0,  1,   0,  0,      1,  'h100,  0, 0,      0,           'h100);
    add(1, 0, 0,      0,  0,  0,           1,   1,  'h100,  1,  'h100,  0, 0,      0,           'h100);
    add(1, 0, 0,      1,  0,  0,           1,   1,  'h100,  0,  0,      0, 0,      0,           'h100);
    add(1, 0, 0,      0,  1,  d(7),        1,   0,  0,      1,  'h104,  0, 0,      0,           'h104);
    add(1, 0, 0,      0,  0,  0,           1,   1,  'h104,  1,  'h104,  1, 'h100,  d(7),        'h104);
    // Redirect coinciding with a response while the buffer holds an entry
    add(1, 0, 0,      1,  0,  0,           0,   1,  'h104,  0,  0,      0, 0,      0,           'h104);
    add(1, 0, 0,      0,  1,  d(8),        0,   0,  0,      1,  'h108,  0, 0,      0,           'h108);
    add(1, 0, 0,      1,  0,  0,           0,   1,  'h108,  0,  0,      1, 'h104,  d(8),        'h108);
    add(1, 1, 'h40,   0,  1,  d(9),        0,   0,  0,      1,  'h40,   0, 0,      0,           'h10c);
    add(1, 0, 0,      0,  0,  0,           1,   1,  'h40,   1,  'h40,   0, 0,      0,           'h40);
    add(1, 0, 0,      1,  0,  0,           1,   1,  'h40,   0,  0,      0, 0,      0,           'h40);
    add(1, 0, 0,      0,  1,  d(10),       1,   0,  0,      1,  'h44,   0, 0,      0,           'h44);
    add(1, 0, 0,      0,  0,  0,           1,   1,  'h44,   1,  'h44,   1, 'h40,   d(10),       'h44);
    // Redirect with a full buffer and decode ready: flushed, no pop shown
    add(1, 0, 0,      1,  0,  0,           0,   1,  'h44,   0,  0,      0, 0,      0,           'h44);
    add(1, 0, 0,      0,  1,  d(11),       0,   0,  0,      1,  'h48,   0, 0,      0,           'h48);
    add(1, 0, 0,      1,  0,  0,           0,   1,  'h48,   0,  0,      1, 'h44,   d(11),       'h48);
    add(1, 0, 0,      0,  1,  d(12),       0,   0,  0,      1,  'h4c,   1, 'h44,   d(11),       'h4c);
    add(1, 1, 'h200,  0,  0,  0,           1,   0,  0,      1,  'h200,  0, 0,      0,           'h4c);
    // Grant withheld three cycles: request and address held stable
    add(1, 0, 0,      0,  0,  0,           1,   1,  'h200,  1,  'h200,  0, 0,      0,           'h200);
    add(1, 0, 0,      0,  0,  0,           1,   1,  'h200,  1,  'h200,  0, 0,      0,           'h200);
    add(1, 0, 0,      0,  0,  0,           1,   1,  'h200,  1,  'h200,  0, 0,      0,           'h200);
    add(1, 0, 0,      1,  0,  0,           1,   1,  'h200,  0,  0,      0, 0,      0,           'h200);
    add(1, 0, 0,      0,  1,  d(13),       1,   0,  0,      1,  'h204,  0, 0,      0,           'h204);
    add(1, 0, 0,      0,  0,  0,           1,   1,  'h204,  1,  'h204,  1, 'h200,  d(13),       'h204);

    for (int i = 0; i < nv; i++) begin
      @(posedge clk); #1;
      rst_n          = vec[i].rst_n;
      redirect_valid = vec[i].rv;
      redirect_pc    = vec[i].rpc;
      imem_gnt       = vec[i].gnt;
      imem_rvalid    = vec[i].rvalid;
      imem_rdata     = vec[i].rdata;
      instr_ready    = vec[i].rdy;
      @(negedge clk);
      chk($sformatf("r%0d_req", i), 32'(imem_req), 32'(vec[i].e_req));
      if (vec[i].e_req) chk($sformatf("r%0d_addr", i), 32'(imem_addr), 32'(vec[i].e_addr));
      chk($sformatf("r%0d_pc_ctrl", i), 32'(pc_ctrl), 32'(vec[i].e_ctrl));
      if (vec[i].e_ctrl) chk($sformatf("r%0d_pc_next", i), 32'(pc_next), 32'(vec[i].e_next));
      chk($sformatf("r%0d_instr_valid", i), 32'(instr_valid), 32'(vec[i].e_iv));
      if (vec[i].e_iv) begin
        chk($sformatf("r%0d_instr_pc", i), 32'(instr_pc), 32'(vec[i].e_ipc));
        chk($sformatf("r%0d_instr", i), instr, vec[i].e_instr);
      end
      chk($sformatf("r%0d_pc", i), 32'(pc), 32'(vec[i].e_pc));
      $display("row %0d: req=%0b addr=%h ctrl=%0b iv=%0b ipc=%h pc=%h",
               i, imem_req, imem_addr, pc_ctrl, instr_valid, instr_pc, pc);
    end

    // Asynchronous reset in WAIT with a buffered entry, then restart from 0x0000
    @(posedge clk); #1;
    redirect_valid = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    chk("ar_first_addr", 32'(imem_addr), 32'h204);
    @(posedge clk); #1;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d(14);
    @(posedge clk); #1;
    imem_gnt = 1'b1; imem_rvalid = 1'b0;
    @(negedge clk);
    chk("ar_head_pc", 32'(instr_pc), 32'h204);
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    #2;
    chk("ar_pre_valid", 32'(instr_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid_low", 32'(instr_valid), 32'd0);
    chk("ar_req_low", 32'(imem_req), 32'd0);
    chk("ar_pc_ctrl", 32'(pc_ctrl), 32'd1);
    $display("async reset: iv=%0b req=%0b ctrl=%0b", instr_valid, imem_req, pc_ctrl);
    @(posedge clk); #1;
    rst_n = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (imem_req) found = 1'b1;
    end
    chk("ar_restart_req", 32'(found), 32'd1);
    chk("ar_restart_addr", 32'(imem_addr), 32'h0);
    chk("ar_restart_pc", 32'(pc), 32'h0);
    $display("restart: req=%0b addr=%h pc=%h", imem_req, imem_addr, pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
